mm_bus_arbiter: RTL and testbench
=================================

Name: mm_bus_arbiter

Overview:
- Arbitrates the CPU's memory-mapped data bus (mm_addr/mm_wdata/mm_we/mm_re/mm_rdata) between two requesters.
  - Requester 0: CPU data port.
  - Requester 1: secondary master, e.g. DMA/debug loader.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences each read or write through a small FSM, returns captured read data and a one-cycle grant/complete pulse.
- Sits between the cpu's mm_* port and the memory/peripheral decode.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, cycles from the mm_re cycle until mm_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  requester 0 transaction request; held until gnt0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  AW  requester 0 address; stable while req0 is high.
- wdata0  in  DW  requester 0 write data; stable while req0 is high.
- gnt0  out  1  one-cycle pulse: requester 0 transaction complete.
- rdata0  out  DW  requester 0 read data; valid from the gnt0 cycle, held until the next requester 0 read completes.
- req1, we1, addr1, wdata1, gnt1, rdata1: same as the requester 0 ports, for requester 1.
- mm_addr  out  AW  bus address.
- mm_wdata  out  DW  bus write data.
- mm_we  out  1  bus write strobe.
- mm_re  out  1  bus read strobe.
- mm_rdata  in  DW  bus read data.
- busy  out  1  high in any state except IDLE.
- contention_cnt  out  16  count of arbitration decisions made with req0 and req1 both high; saturates at 16'hFFFF.

Behaviour:
- Reset (clk edge with rst_n=0):
  - State goes to IDLE.
  - All outputs become 0: mm_*, gnt*, rdata*, busy, contention_cnt.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high: select the winner, latch owner/we/addr/wdata into registers, go to ISSUE.
  - Winner rule: the sole requester; if both are high, the requester != last.
  - If both are high, increment contention_cnt, saturating.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mm_addr/mm_wdata are driven from the latched registers.
  - mm_we = latched we; mm_re = ~latched we.
  - Write: go to DONE.
  - Read: load wait counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 0, capture mm_rdata into the owner's rdata register and go to DONE.
  - mm_re/mm_we are 0; mm_addr stays driven.
- DONE (1 cycle):
  - Owner's gnt is high; last = owner; go to IDLE.
- Outside ISSUE/WAIT, mm_addr and mm_wdata are 0. mm_we and mm_re are registered outputs and are never high together.
- Latency, with req sampled in IDLE at cycle N:
  - Strobe in cycle N+1.
  - Write gnt at N+2.
  - Read gnt at N+2+RD_LAT.
- Back-to-back: at least one IDLE cycle follows every DONE. A requester must drop req on the edge ending its gnt cycle, or that req is treated as a new request.
- Requester drops req before gnt: the latched transaction still completes and gnt still pulses. Inputs are latched, so later changes have no effect.
- Non-owner inputs are ignored while busy; they are considered only in the next IDLE.
- Reset mid-transaction: in-flight transaction is abandoned, no gnt, no rdata update; normal service resumes after reset.
- Only one gnt is ever high per cycle.

Optional Feature:
- Macro: MM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both req are high; last is unused; contention_cnt still counts.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: rst_n=0 for 2 edges with req0=1 -> all outputs 0, no mm_re/mm_we; after release, first strobe appears 2 cycles later.
- Read, requester 0: addr0=16'hC004, bus model returns 16'hAAAA, RD_LAT=1 -> mm_re high only at N+1 with mm_addr=16'hC004; gnt0 at N+3; rdata0=16'hAAAA; busy high N+1..N+3.
- Write, requester 1: addr1=16'h0010, wdata1=16'h1234 -> mm_we high only at N+1 with mm_addr=16'h0010, mm_wdata=16'h1234; gnt1 at N+2; mm_re stays 0; rdata1 unchanged.
- Contention: req0 and req1 both high, each requester re-requests after its gnt -> grants alternate 0,1,0,1 (first is 0); contention_cnt=4 after 4 grants; never both gnt in one cycle.
- Reset mid-read: RD_LAT=3, assert rst_n=0 during WAIT -> no gnt0, rdata0=0; a new req1 read afterwards completes with gnt1 at N+5.
- MM_ARB_FIXED_PRIO_EN defined, both held for 4 transactions -> all four grants go to requester 0, gnt1 never pulses, contention_cnt=4.

Source files
------------

// File: rtl/mm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mm_bus_arbiter
//
// Shares one memory-mapped data bus between two requesters: requester 0 is
// the CPU data port and requester 1 is a secondary master such as a DMA or
// debug loader. Only one transaction is in flight at a time. Each read or
// write passes through IDLE -> ISSUE -> (WAIT) -> DONE.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// it high until gntN. gntN is a one-cycle completion pulse. The request must
// be low on the clock edge that ends the gnt cycle, otherwise it is taken as
// a new request. Request fields are latched when the transaction wins, so a
// requester that drops req early still gets its gnt.
//
// Arbitration: round-robin. When both requesters ask at once, the one that
// was not served last wins, and requester 0 wins the first tie after reset.
// If MM_ARB_FIXED_PRIO_EN is defined, requester 0 always wins a tie instead.
//
// Parameters: AW address width, DW data width, RD_LAT cycles from the mm_re
// cycle until mm_rdata is valid (1..15).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req/we/addr/wdata 0  requester 0 transaction request
//   gnt0, rdata0         requester 0 completion pulse, captured read data
//   req/we/addr/wdata 1  requester 1 transaction request
//   gnt1, rdata1         requester 1 completion pulse, captured read data
//   mm_addr/mm_wdata     bus address and write data (0 outside ISSUE/WAIT)
//   mm_we/mm_re          registered one-cycle bus strobes
//   mm_rdata             bus read data
//   busy                 high in any state other than IDLE
//   contention_cnt       saturating count of arbitration decisions where
//                        both requesters were asking
// ---------------------------------------------------------------------------
module mm_bus_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mm_addr,
  output logic [DW-1:0] mm_wdata,
  output logic          mm_we,
  output logic          mm_re,
  input  logic [DW-1:0] mm_rdata,
  output logic          busy,
  output logic [15:0]   contention_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Wait counter start value: WAIT lasts RD_LAT cycles after ISSUE.
  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  state_t        state_q;
  logic          owner_q;
  logic          we_q;
  logic [3:0]    wcnt_q;
  logic [AW-1:0] mm_addr_q;
  logic [DW-1:0] mm_wdata_q;
  logic          mm_we_q;
  logic          mm_re_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          busy_q;
  logic [15:0]   cnt_q;
`ifndef MM_ARB_FIXED_PRIO_EN
  logic          last_q;
`endif

  // Winner selection and the winner's request fields.
  logic          both_d;
  logic          win_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  always_comb begin
    both_d = req0 & req1;
`ifdef MM_ARB_FIXED_PRIO_EN
    win_d = ~req0;
`else
    // A tie goes to the requester that was not served last; otherwise the
    // only active requester wins.
    win_d = both_d ? ~last_q : req1;
`endif
    sel_we_d    = win_d ? we1    : we0;
    sel_addr_d  = win_d ? addr1  : addr0;
    sel_wdata_d = win_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      wcnt_q     <= '0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      mm_we_q    <= 1'b0;
      mm_re_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
`ifndef MM_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 | req1) begin
            // Strobes and bus fields are loaded here so they are visible
            // in the ISSUE cycle straight from registers.
            owner_q    <= win_d;
            we_q       <= sel_we_d;
            mm_addr_q  <= sel_addr_d;
            mm_wdata_q <= sel_wdata_d;
            mm_we_q    <= sel_we_d;
            mm_re_q    <= ~sel_we_d;
            busy_q     <= 1'b1;
            if (both_d && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mm_we_q <= 1'b0;
          mm_re_q <= 1'b0;
          if (we_q) begin
            mm_addr_q  <= '0;
            mm_wdata_q <= '0;
            gnt0_q     <= ~owner_q;
            gnt1_q     <= owner_q;
            state_q    <= S_DONE;
          end else begin
            wcnt_q  <= WAIT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            if (owner_q) rdata1_q <= mm_rdata;
            else         rdata0_q <= mm_rdata;
            mm_addr_q  <= '0;
            mm_wdata_q <= '0;
            gnt0_q     <= ~owner_q;
            gnt1_q     <= owner_q;
            state_q    <= S_DONE;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_DONE: begin
`ifndef MM_ARB_FIXED_PRIO_EN
          last_q <= owner_q;
`endif
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mm_addr        = mm_addr_q;
  assign mm_wdata       = mm_wdata_q;
  assign mm_we          = mm_we_q;
  assign mm_re          = mm_re_q;
  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign busy           = busy_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mm_bus_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model predicts, from the cycle in which a request is accepted,
// the strobe cycle and the gnt cycle, and from those every bus output of
// every cycle. A queue of expected grant owners is matched against observed
// gnt pulses.
// ---------------------------------------------------------------------------
module tb_mm_bus_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_wdata;
  logic          mm_we, mm_re;
  logic [DW-1:0] mm_rdata;
  logic          busy;
  logic [15:0]   contention_cnt;

  mm_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_we(mm_we), .mm_re(mm_re),
    .mm_rdata(mm_rdata), .busy(busy), .contention_cnt(contention_cnt)
  );

  // ---------------- reference model state ----------------
  int            cyc;
  bit            m_act;
  bit            m_own;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rd;
  int            m_s, m_g;
  bit            m_last;
  logic [15:0]   m_cnt;
  logic [DW-1:0] m_rdata0, m_rdata1;
  logic [DW-1:0] rd_next;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int         gnt_log[$];
  int         last_gnt_cyc;
  int         n_chk;
  int         n_fail;
  bit         chk_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_act    = 1'b0;
    m_last   = 1'b1;
    m_cnt    = '0;
    m_rdata0 = '0;
    m_rdata1 = '0;
    exp_q.delete();
  endtask

  // Advance the model across the clock edge that ends cycle cyc.
  task automatic model_edge();
    bit both;
    both = req0 && req1;
    if (!rst_n) begin
      model_reset();
    end else if (m_act) begin
      if (!m_we && cyc == m_g - 1) begin
        if (m_own) m_rdata1 = m_rd;
        else       m_rdata0 = m_rd;
      end
      if (cyc == m_g) begin
        m_last = m_own;
        m_act  = 1'b0;
      end
    end else if (req0 || req1) begin
`ifdef MM_ARB_FIXED_PRIO_EN
      if (req0) m_own = 1'b0;
      else      m_own = 1'b1;
`else
      if (both)      m_own = (m_last == 1'b0);
      else if (req0) m_own = 1'b0;
      else           m_own = 1'b1;
`endif
      m_we    = m_own ? we1 : we0;
      m_addr  = m_own ? addr1 : addr0;
      m_wdata = m_own ? wdata1 : wdata0;
      m_rd    = rd_next;
      m_s     = cyc + 1;
      m_g     = m_we ? cyc + 2 : cyc + 2 + RD_LAT;
      m_act   = 1'b1;
      if (both && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      exp_q.push_back(m_own);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, apply requester
  // drop-on-gnt and bus read data, update the model, then cross the edge.
  task automatic step();
    logic [0:0]    e;
    bit            in_bus;
    @(negedge clk);
    if (chk_en) begin
      in_bus = m_act && cyc >= m_s && cyc < m_g;
      chk("busy",     32'(busy),     32'(m_act && cyc >= m_s && cyc <= m_g));
      chk("mm_re",    32'(mm_re),    32'(m_act && !m_we && cyc == m_s));
      chk("mm_we",    32'(mm_we),    32'(m_act && m_we && cyc == m_s));
      chk("mm_addr",  32'(mm_addr),  in_bus ? 32'(m_addr) : 32'd0);
      chk("mm_wdata", 32'(mm_wdata), in_bus ? 32'(m_wdata) : 32'd0);
      chk("gnt0",     32'(gnt0),     32'(m_act && cyc == m_g && !m_own));
      chk("gnt1",     32'(gnt1),     32'(m_act && cyc == m_g && m_own));
      chk("one_gnt",  32'(gnt0 & gnt1), 32'd0);
      chk("rdata0",   32'(rdata0),   32'(m_rdata0));
      chk("rdata1",   32'(rdata1),   32'(m_rdata1));
      chk("cont_cnt", 32'(contention_cnt), 32'(m_cnt));
      if (gnt0 || gnt1) begin
        gnt_log.push_back(gnt1 ? 1 : 0);
        last_gnt_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'({gnt1, gnt0}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("gnt_owner", 32'(gnt1), 32'(e));
        end
      end
    end
    if (m_act && cyc == m_g) begin
      if (m_own) req1 = 1'b0;
      else       req0 = 1'b0;
    end
    if (m_act && !m_we && cyc == m_g - 1) mm_rdata = m_rd;
    else                                  mm_rdata = DW'($urandom);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run until nothing is pending, bounded by max_cyc.
  task automatic run_until_idle(input int max_cyc, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (!m_act && !req0 && !req1) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_sample;
  int log_start;
  int exp_order[4];
  bit got4;

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0; cyc = 0; last_gnt_cyc = -1;
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hC004; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0;      wdata1 = '0;
    mm_rdata = '0; rd_next = 16'hAAAA;
    model_reset();

    // Reset held for two edges with req0 asserted.
    @(posedge clk); #1; cyc++;
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;

    // Read by requester 0, bus returns AAAA.
    n_sample = cyc;
    run_until_idle(30, "rd0_timeout");
    chk("rd0_data", 32'(rdata0), 32'h0000AAAA);
    chk("rd0_latency", 32'(last_gnt_cyc - n_sample), 32'(2 + RD_LAT));

    // Write by requester 1.
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'h1234;
    n_sample = cyc;
    run_until_idle(30, "wr1_timeout");
    chk("wr1_latency", 32'(last_gnt_cyc - n_sample), 32'd2);
    chk("wr1_rdata1", 32'(rdata1), 32'd0);

    // Contention: both keep re-requesting.
    log_start = gnt_log.size();
    we0 = 1'b1; addr0 = 16'h0100; wdata0 = 16'h5555;
    we1 = 1'b0; addr1 = 16'h0200; rd_next = 16'h7E7E;
    got4 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      req0 = 1'b1; req1 = 1'b1;
      step();
      if (gnt_log.size() - log_start >= 4) begin
        got4 = 1'b1;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_timeout", 32'(got4), 32'd1);
`ifdef MM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++)
      if (log_start + i < gnt_log.size())
        chk("cont_order", 32'(gnt_log[log_start + i]), 32'(exp_order[i]));
    chk("cont_cnt4", 32'(contention_cnt), 32'd4);
    run_until_idle(30, "cont_drain");

    // Reset in the middle of a read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0BAD; rd_next = 16'hBEEF;
    repeat (3) step();
    rst_n = 1'b0; req0 = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_cnt", 32'(contention_cnt), 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0042; rd_next = 16'h4321;
    n_sample = cyc;
    run_until_idle(30, "rst_rd1_timeout");
    chk("rst_rd1_latency", 32'(last_gnt_cyc - n_sample), 32'd5);
    chk("rst_rd1_data", 32'(rdata1), 32'h00004321);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rd_next = DW'($urandom);
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
      end else if (req0 && $urandom_range(0, 49) == 0) begin
        req0 = 1'b0;
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
      end else if (req1 && $urandom_range(0, 49) == 0) begin
        req1 = 1'b0;
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    run_until_idle(40, "rand_drain");
    repeat (2) step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
